// File: rtl/sramlike_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sramlike_ram_responder_pkg
// Purpose : Shared types and helpers for the sram-like RAM responder:
//           transfer-size encodings, byte-lane enable decode, response
//           FIFO entry and in-flight access descriptor.
// Revision: 1.0 - initial release
// ============================================================================
package sramlike_ram_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_sel_e;

  // One queued response: writes carry zero data but still occupy a slot
  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
  } resp_entry_t;

  // Access issued to the RAM last cycle, whose result lands this cycle
  typedef struct packed {
    logic      valid;
    port_sel_e port;
    logic      is_wr;
  } inflight_t;

  // Byte-lane write enables; the reserved size 3 writes nothing
  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sramlike_ram_responder_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sramlike_resp_fifo
// Purpose : Per-port response queue. Tracks outstanding transactions
//           (in flight + queued) to throttle acceptance, holds returned
//           responses in order, and releases each one after WAIT cycles
//           at the head of the queue.
// Revision: 1.0 - initial release
// ============================================================================
module sramlike_resp_fifo
  import sramlike_ram_responder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WAIT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        push,
  input  resp_entry_t push_entry,
  output logic        can_accept,
  output logic        dataok,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (WAIT < 1) ? 1 : $clog2(WAIT + 1);
  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_V  = WW'(WAIT);

  resp_entry_t   mem_q [DEPTH];
  resp_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          nonempty;

  assign nonempty   = (cnt_q != '0);
  assign dataok     = ~reset & nonempty & (wcnt_q == WAIT_V);
  assign can_accept = ~reset & (occ_q < DEPTH_V);
  assign rdata      = dataok ? mem_q[rptr_q].data : 32'd0;

  // Next-state for queue storage, pointers, counters and head wait timer
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    occ_d  = occ_q;
    wcnt_d = wcnt_q;

    if (push) begin
      mem_d[wptr_q] = push_entry;
      wptr_d        = wptr_q + AW'(1);
    end
    if (dataok) begin
      rptr_d = rptr_q + AW'(1);
    end

    if (push && !dataok) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && dataok) begin
      cnt_d = cnt_q - CW'(1);
    end

    // Occupancy spans acceptance to response, so a push can never overflow
    if (accept && !dataok) begin
      occ_d = occ_q + CW'(1);
    end else if (!accept && dataok) begin
      occ_d = occ_q - CW'(1);
    end

    if (dataok) begin
      wcnt_d = '0;
    end else if (nonempty && (wcnt_q < WAIT_V)) begin
      wcnt_d = wcnt_q + WW'(1);
    end
  end

  // Control state register; reset drops everything queued or in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      occ_q  <= '0;
      wcnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      occ_q  <= occ_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by cnt_q
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/sramlike_ram_responder.sv
`default_nettype none
// ============================================================================
// Module  : sramlike_ram_responder
// Purpose : Slave end of the CPU inst/data sram-like ports. Arbitrates the
//           two ports (data first) onto one synchronous single-port RAM and
//           returns in-order responses per port after programmable waits.
// Revision: 1.0 - initial release
// ============================================================================
module sramlike_ram_responder
  import sramlike_ram_responder_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int INST_WAIT = 0,
  parameter int DATA_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addrok,
  output logic        inst_sram_dataok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addrok,
  output logic        data_sram_dataok,
  output logic [31:0] data_sram_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  logic        can_i, can_d;
  logic        inst_grant, data_grant;
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic        push_i, push_d;
  resp_entry_t ret_entry;
  inflight_t   inflight_q, inflight_d;

  // Strict data priority: inst only wins when data is not granted
  assign data_grant       = data_sram_req & can_d;
  assign inst_grant       = inst_sram_req & can_i & ~data_grant;
  assign data_sram_addrok = data_grant;
  assign inst_sram_addrok = inst_grant;

  // Steer the granted port's request onto the RAM in the grant cycle
  always_comb begin
    sel_wr    = data_grant ? data_sram_wr    : inst_sram_wr;
    sel_size  = data_grant ? data_sram_size  : inst_sram_size;
    sel_addr  = data_grant ? data_sram_addr  : inst_sram_addr;
    ram_wdata = data_grant ? data_sram_wdata : inst_sram_wdata;
    ram_en    = inst_grant | data_grant;
    ram_addr  = {sel_addr[31:2], 2'b00};
    ram_wen   = (ram_en && sel_wr) ? byte_en(sel_size, sel_addr[1:0]) : 4'b0000;
  end

  // Remember which port owns the RAM result arriving next cycle
  always_comb begin
    inflight_d.valid = ram_en;
    inflight_d.port  = data_grant ? PORT_DATA : PORT_INST;
    inflight_d.is_wr = sel_wr;
  end

  // In-flight descriptor register
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // Route the returning RAM word (or a zero write-ack) to its port's queue
  always_comb begin
    push_i          = inflight_q.valid & (inflight_q.port == PORT_INST);
    push_d          = inflight_q.valid & (inflight_q.port == PORT_DATA);
    ret_entry.is_wr = inflight_q.is_wr;
    ret_entry.data  = inflight_q.is_wr ? 32'd0 : ram_rdata;
  end

  sramlike_resp_fifo #(
    .DEPTH (DEPTH),
    .WAIT  (INST_WAIT)
  ) u_inst_fifo (
    .clk        (clk),
    .reset      (reset),
    .accept     (inst_grant),
    .push       (push_i),
    .push_entry (ret_entry),
    .can_accept (can_i),
    .dataok     (inst_sram_dataok),
    .rdata      (inst_sram_rdata)
  );

  sramlike_resp_fifo #(
    .DEPTH (DEPTH),
    .WAIT  (DATA_WAIT)
  ) u_data_fifo (
    .clk        (clk),
    .reset      (reset),
    .accept     (data_grant),
    .push       (push_d),
    .push_entry (ret_entry),
    .can_accept (can_d),
    .dataok     (data_sram_dataok),
    .rdata      (data_sram_rdata)
  );

endmodule
`default_nettype wire
